lsu_dmem_if: RTL and testbench

Load/store bus interface for the pipelined RV32I core, sitting in the MEM stage directly upstream of the load-extension unit. It accepts one memory operation from EX/MEM, runs a request/grant/response handshake on the data-memory bus, and generates byte strobes and replicated write data for stores. For loads it returns the read word right-justified and zero-filled; the downstream extender applies sign or zero extension. It stalls the pipeline until the operation retires and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_dmem_if_if.sv | 22 ++
 rtl/lsu_dmem_if.sv | 179 +++++++++++++++++
 tb/tb_lsu_dmem_if.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_if_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the memory or
// interconnect (slave). Request fields must stay stable until the grant.
interface lsu_dmem_if_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_dmem_if.sv
// MEM-stage load/store unit: one op at a time over a req/gnt/rvalid bus,
// with store lane steering, right-justified load data and a bus watchdog.
module lsu_dmem_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_mem_len,
  output logic        lsu_stall,
  lsu_dmem_if_if.master bus,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign_err,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t r_state, w_state_nxt;

  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [1:0]       r_off;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_ld_data;
  logic             r_ld_ok;
  logic             r_mis;
  logic             r_to;

  logic        w_start;
  logic        w_len_onehot;
  logic        w_misalign;
  logic        w_wd_hit;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_start      = ex_valid & (ex_is_load | ex_is_store);
  assign w_len_onehot = (ex_mem_len == 3'b001) | (ex_mem_len == 3'b010) |
                        (ex_mem_len == 3'b100);
  assign w_misalign   = ~w_len_onehot | (ex_mem_len[1] & ex_addr[0]) |
                        (ex_mem_len[2] & (|ex_addr[1:0]));
  // The counter holds the number of REQ/WAIT cycles already spent, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign w_wd_hit     = WD_EN && (r_cnt == CNT_LAST);

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an incomplete case/if silently infers a latch.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'h0;
    if (!ex_is_load) begin
      case (ex_mem_len)
        3'b001: begin
          w_wstrb = 4'b0001 << ex_addr[1:0];
          w_wdata = {4{ex_wdata[7:0]}};
        end
        3'b010: begin
          w_wstrb = 4'b0011 << ex_addr[1:0];
          w_wdata = {2{ex_wdata[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = ex_wdata;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A grant or read response in the watchdog's last cycle still completes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = w_misalign ? S_DONE : S_REQ;
      S_REQ: begin
        if (bus.dmem_gnt)  w_state_nxt = r_we ? S_DONE : S_WAIT;
        else if (w_wd_hit) w_state_nxt = S_DONE;
      end
      S_WAIT: begin
        if (bus.dmem_rvalid) w_state_nxt = S_DONE;
        else if (w_wd_hit)   w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall    = 1'b0;
    ld_valid     = 1'b0;
    misalign_err = 1'b0;
    bus_timeout  = 1'b0;
    case (r_state)
      S_IDLE:        lsu_stall = w_start;
      S_REQ, S_WAIT: lsu_stall = 1'b1;
      default: begin
        ld_valid     = r_ld_ok;
        misalign_err = r_mis;
        bus_timeout  = r_to;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_off     <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_ld_data <= '0;
      r_ld_ok   <= 1'b0;
      r_mis     <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_req <= (w_state_nxt == S_REQ);
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_ld_ok <= 1'b0;
          r_to    <= 1'b0;
          r_mis   <= w_start & w_misalign;
          if (w_start && !w_misalign) begin
            r_we    <= ~ex_is_load;
            r_addr  <= {ex_addr[31:2], 2'b00};
            r_off   <= ex_addr[1:0];
            r_wstrb <= w_wstrb;
            r_wdata <= w_wdata;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!bus.dmem_gnt && w_wd_hit) begin
            r_to      <= 1'b1;
            r_ld_data <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.dmem_rvalid) begin
            r_ld_data <= bus.dmem_rdata >> {r_off, 3'b000};
            r_ld_ok   <= 1'b1;
          end else if (w_wd_hit) begin
            r_to      <= 1'b1;
            r_ld_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wstrb = r_wstrb;
  assign bus.dmem_wdata = r_wdata;
  assign ld_data        = r_ld_data;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Bench for lsu_dmem_if: unit 0 uses the default watchdog, unit 1 a 4-cycle
// watchdog. Stimulus queues expected responses; a monitor pops and compares.
module tb_lsu_dmem_if;

  typedef enum int {K_LOAD, K_STORE, K_MIS, K_TO} kind_e;

  typedef struct {
    int          u;
    logic        ld_valid;
    logic        mis;
    logic        to;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    int          u;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          u;
    logic        ld, st;
    logic [31:0] addr, wdata;
    logic [2:0]  len;
    logic [31:0] rdata;
    int          gd, stall;
    kind_e       kind;
    logic [31:0] data, baddr;
    logic [3:0]  wstrb;
    logic [31:0] bwdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ex_valid_v;
  logic        ex_is_load, ex_is_store;
  logic [31:0] ex_addr, ex_wdata;
  logic [2:0]  ex_mem_len;

  logic [1:0]  stall_v, ld_valid_v, mis_v, to_v, req_v, we_v;
  logic [31:0] ld_data_v [2];
  logic [1:0]  gnt_v, rvalid_v;
  logic [31:0] rdata_v [2];

  logic [1:0]  auto_v, pend_rv, pend_req;
  int          gd_v [2];
  int          wait_v [2];
  int          req_cyc [2];
  logic [31:0] next_rdata [2];

  int n_checks, n_errors;
  rsp_t q_rsp[$];
  req_t q_req[$];
  rsp_t e_rsp;
  req_t e_req;

  always #5 clk = ~clk;

  lsu_dmem_if_if bus0 ();
  lsu_dmem_if_if bus1 ();

  assign req_v = {bus1.dmem_req, bus0.dmem_req};
  assign we_v  = {bus1.dmem_we,  bus0.dmem_we};
  assign bus0.dmem_gnt    = gnt_v[0];
  assign bus0.dmem_rvalid = rvalid_v[0];
  assign bus0.dmem_rdata  = rdata_v[0];
  assign bus1.dmem_gnt    = gnt_v[1];
  assign bus1.dmem_rvalid = rvalid_v[1];
  assign bus1.dmem_rdata  = rdata_v[1];

  lsu_dmem_if u_dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid_v[0]), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_mem_len(ex_mem_len),
    .lsu_stall(stall_v[0]), .bus(bus0), .ld_data(ld_data_v[0]),
    .ld_valid(ld_valid_v[0]), .misalign_err(mis_v[0]), .bus_timeout(to_v[0])
  );

  lsu_dmem_if #(.TIMEOUT_CYCLES(4)) u_dut_wd (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid_v[1]), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_mem_len(ex_mem_len),
    .lsu_stall(stall_v[1]), .bus(bus1), .ld_data(ld_data_v[1]),
    .ld_valid(ld_valid_v[1]), .misalign_err(mis_v[1]), .bus_timeout(to_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response and bus-request monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) pend_req = 2'b00;
    else for (int i = 0; i < 2; i++) begin
      if (ld_valid_v[i] || mis_v[i] || to_v[i]) begin
        if (q_rsp.size() == 0)
          check($sformatf("rsp%0d unexpected", i), {29'd0, ld_valid_v[i], mis_v[i], to_v[i]}, 32'd0);
        else begin
          e_rsp = q_rsp.pop_front();
          check($sformatf("rsp%0d unit", i), i, e_rsp.u);
          check($sformatf("rsp%0d flags", i), {29'd0, ld_valid_v[i], mis_v[i], to_v[i]},
                {29'd0, e_rsp.ld_valid, e_rsp.mis, e_rsp.to});
          if (e_rsp.ld_valid || e_rsp.to)
            check($sformatf("rsp%0d ld_data", i), ld_data_v[i], e_rsp.data);
        end
      end
      if (req_v[i]) begin
        req_cyc[i]++;
        if (q_req.size() == 0)
          check($sformatf("req%0d unexpected", i), req_v[i], 1'b0);
        else begin
          e_req = q_req[0];
          check($sformatf("req%0d unit", i), i, e_req.u);
          check($sformatf("req%0d we", i), we_v[i], e_req.we);
          check($sformatf("req%0d addr", i), (i == 0) ? bus0.dmem_addr : bus1.dmem_addr, e_req.addr);
          check($sformatf("req%0d wstrb", i), (i == 0) ? bus0.dmem_wstrb : bus1.dmem_wstrb, e_req.wstrb);
          if (e_req.we)
            check($sformatf("req%0d wdata", i), (i == 0) ? bus0.dmem_wdata : bus1.dmem_wdata, e_req.wdata);
          if (gnt_v[i]) begin
            void'(q_req.pop_front());
            pend_req[i] = 1'b0;
          end else pend_req[i] = 1'b1;
        end
      end else if (pend_req[i]) begin
        void'(q_req.pop_front());
        pend_req[i] = 1'b0;
      end
    end
  end

  // Bus responder: grant after gd_v idle REQ cycles, read data one cycle later.
  initial forever begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      if (auto_v[i]) begin
        gnt_v[i]    = 1'b0;
        rvalid_v[i] = 1'b0;
        if (pend_rv[i]) begin
          rvalid_v[i] = 1'b1;
          rdata_v[i]  = next_rdata[i];
          pend_rv[i]  = 1'b0;
        end else if (req_v[i]) begin
          if (wait_v[i] >= gd_v[i]) begin
            gnt_v[i]   = 1'b1;
            wait_v[i]  = 0;
            pend_rv[i] = ~we_v[i];
          end else wait_v[i]++;
        end else wait_v[i] = 0;
      end
    end
  end

  function automatic vec_t mk(input int u, input logic ld, input logic st,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] len, input logic [31:0] rdata,
                              input int gd, input int stall, input kind_e kind,
                              input logic [31:0] data, input logic [31:0] baddr,
                              input logic [3:0] wstrb, input logic [31:0] bwdata);
    vec_t v;
    v.u = u; v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.len = len;
    v.rdata = rdata; v.gd = gd; v.stall = stall; v.kind = kind; v.data = data;
    v.baddr = baddr; v.wstrb = wstrb; v.bwdata = bwdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int   stalls;
    logic s;
    case (v.kind)
      K_LOAD: q_rsp.push_back('{u:v.u, ld_valid:1'b1, mis:1'b0, to:1'b0, data:v.data});
      K_MIS:  q_rsp.push_back('{u:v.u, ld_valid:1'b0, mis:1'b1, to:1'b0, data:32'h0});
      K_TO:   q_rsp.push_back('{u:v.u, ld_valid:1'b0, mis:1'b0, to:1'b1, data:32'h0});
      default: ;
    endcase
    if (v.kind != K_MIS)
      q_req.push_back('{u:v.u, we:(v.kind == K_STORE), addr:v.baddr, wstrb:v.wstrb, wdata:v.bwdata});
    gd_v[v.u]       = v.gd;
    next_rdata[v.u] = v.rdata;
    ex_is_load  = v.ld;
    ex_is_store = v.st;
    ex_addr     = v.addr;
    ex_wdata    = v.wdata;
    ex_mem_len  = v.len;
    ex_valid_v[v.u] = 1'b1;
    stalls = 0;
    do begin
      @(negedge clk);
      s = stall_v[v.u];
      if (s) stalls++;
      @(posedge clk);
      #1;
    end while (s && stalls < 64);
    ex_valid_v[v.u] = 1'b0;
    check($sformatf("stall cycles u%0d @%h", v.u, v.addr), stalls, v.stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; ex_valid_v = 2'b00; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_addr = '0; ex_wdata = '0; ex_mem_len = 3'b100;
    gnt_v = 2'b00; rvalid_v = 2'b00; rdata_v[0] = '0; rdata_v[1] = '0;
    auto_v = 2'b11; pend_rv = 2'b00; pend_req = 2'b00;
    gd_v[0] = 0; gd_v[1] = 0; wait_v[0] = 0; wait_v[1] = 0;
    req_cyc[0] = 0; req_cyc[1] = 0; next_rdata[0] = '0; next_rdata[1] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset stall", stall_v, 2'b00);
    check("reset req", req_v, 2'b00);
    check("reset we", we_v, 2'b00);
    check("reset addr", bus0.dmem_addr, 32'h0);
    check("reset wstrb", bus0.dmem_wstrb, 4'h0);
    check("reset wdata", bus0.dmem_wdata, 32'h0);
    check("reset ld_data", ld_data_v[0], 32'h0);
    check("reset pulses", {ld_valid_v, mis_v, to_v}, 6'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // u  ld st addr          wdata         len     rdata         gd stall kind     data          baddr         wstrb    bwdata
    run_vec(mk(0, 1, 0, 32'h100, 32'h0,        3'b100, 32'hDEADBEEF, 0, 3, K_LOAD,  32'hDEADBEEF, 32'h100, 4'b0000, 32'h0));
    run_vec(mk(0, 1, 0, 32'h103, 32'h0,        3'b001, 32'h80AABBCC, 0, 3, K_LOAD,  32'h00000080, 32'h100, 4'b0000, 32'h0));
    run_vec(mk(0, 1, 0, 32'h102, 32'h0,        3'b010, 32'h1234ABCD, 0, 3, K_LOAD,  32'h00001234, 32'h100, 4'b0000, 32'h0));
    run_vec(mk(0, 1, 0, 32'h100, 32'h0,        3'b010, 32'h1234ABCD, 0, 3, K_LOAD,  32'h1234ABCD, 32'h100, 4'b0000, 32'h0));
    run_vec(mk(0, 1, 0, 32'h101, 32'h0,        3'b001, 32'h11223344, 1, 4, K_LOAD,  32'h00112233, 32'h100, 4'b0000, 32'h0));
    run_vec(mk(0, 0, 1, 32'h201, 32'h000000A5, 3'b001, 32'h0,        3, 5, K_STORE, 32'h0,        32'h200, 4'b0010, 32'hA5A5A5A5));
    run_vec(mk(0, 0, 1, 32'h200, 32'h123456C3, 3'b001, 32'h0,        0, 2, K_STORE, 32'h0,        32'h200, 4'b0001, 32'hC3C3C3C3));
    run_vec(mk(0, 0, 1, 32'h303, 32'h0000005A, 3'b001, 32'h0,        0, 2, K_STORE, 32'h0,        32'h300, 4'b1000, 32'h5A5A5A5A));
    run_vec(mk(0, 0, 1, 32'h302, 32'hFFFFBEEF, 3'b010, 32'h0,        0, 2, K_STORE, 32'h0,        32'h300, 4'b1100, 32'hBEEFBEEF));
    run_vec(mk(0, 0, 1, 32'h300, 32'h12345678, 3'b100, 32'h0,        0, 2, K_STORE, 32'h0,        32'h300, 4'b1111, 32'h12345678));
    run_vec(mk(0, 1, 0, 32'h102, 32'h0,        3'b100, 32'h0,        0, 1, K_MIS,   32'h0,        32'h0,   4'b0000, 32'h0));
    run_vec(mk(0, 0, 1, 32'h301, 32'h0,        3'b010, 32'h0,        0, 1, K_MIS,   32'h0,        32'h0,   4'b0000, 32'h0));
    run_vec(mk(0, 1, 0, 32'h100, 32'h0,        3'b011, 32'h0,        0, 1, K_MIS,   32'h0,        32'h0,   4'b0000, 32'h0));
    run_vec(mk(0, 1, 0, 32'h100, 32'h0,        3'b000, 32'h0,        0, 1, K_MIS,   32'h0,        32'h0,   4'b0000, 32'h0));
    run_vec(mk(0, 1, 1, 32'h104, 32'hFFFFFFFF, 3'b100, 32'hCAFEF00D, 0, 3, K_LOAD,  32'hCAFEF00D, 32'h104, 4'b0000, 32'h0));

    // Valid without a load or store is not an operation.
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_valid_v[0] = 1'b1;
    #1;
    check("no-op stall", stall_v[0], 1'b0);
    @(posedge clk);
    #1;
    check("no-op req", req_v[0], 1'b0);
    ex_valid_v[0] = 1'b0;

    // Reset while waiting for read data, then a stale rvalid.
    auto_v[0] = 1'b0;
    q_req.push_back('{u:0, we:1'b0, addr:32'h400, wstrb:4'b0000, wdata:32'h0});
    ex_is_load = 1'b1; ex_addr = 32'h400; ex_mem_len = 3'b100; ex_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    gnt_v[0] = 1'b1;
    @(posedge clk);
    #1;
    gnt_v[0] = 1'b0;
    check("wait stall", stall_v[0], 1'b1);
    rst = 1'b1;
    ex_valid_v[0] = 1'b0;
    #1;
    check("mid-op reset stall", stall_v[0], 1'b0);
    check("mid-op reset req", req_v[0], 1'b0);
    check("mid-op reset addr", bus0.dmem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rvalid_v[0] = 1'b1; rdata_v[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rvalid_v[0] = 1'b0;
    @(posedge clk);
    #1;
    check("stale rvalid ld_data", ld_data_v[0], 32'h0);
    auto_v[0] = 1'b1;
    run_vec(mk(0, 1, 0, 32'h104, 32'h0, 3'b100, 32'h0BADF00D, 0, 3, K_LOAD, 32'h0BADF00D, 32'h104, 4'b0000, 32'h0));

    // Watchdog instance: a good load first, then a load that is never granted.
    run_vec(mk(1, 1, 0, 32'h500, 32'h0, 3'b100, 32'h55AA55AA, 0,    3, K_LOAD, 32'h55AA55AA, 32'h500, 4'b0000, 32'h0));
    req_cyc[1] = 0;
    run_vec(mk(1, 1, 0, 32'h602, 32'h0, 3'b010, 32'h0,        1000, 5, K_TO,   32'h0,        32'h600, 4'b0000, 32'h0));
    check("timeout req cycles", req_cyc[1], 4);
    auto_v[1] = 1'b0;
    rvalid_v[1] = 1'b1; rdata_v[1] = 32'h12345678;
    @(posedge clk);
    #1;
    rvalid_v[1] = 1'b0;
    @(posedge clk);
    #1;
    check("post-timeout ld_data", ld_data_v[1], 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("rsp queue drained", q_rsp.size(), 0);
    check("req queue drained", q_req.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
